// File: rtl/riscv_cache_pkg.sv
// Shared types and helpers for the write-back data cache.
package riscv_cache_pkg;

  // Controller states: serve hits, flush a dirty victim, or fetch a new line.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

  // Ceiling log2 used for every derived width; never returns less than 1.
  function automatic int cache_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/riscv_dcache_wb_if.sv
// CPU-side and memory-side signals of the data cache.
// Handshake: the CPU holds proc_read/proc_write, proc_addr and proc_wdata
// stable while proc_stall=1; a request completes in the first cycle it
// sees proc_stall=0. The cache holds mem_read/mem_write, mem_addr and
// mem_wdata stable until a cycle in which mem_ready=1 completes the transfer.
interface riscv_dcache_wb_if
  import riscv_cache_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 30,
  parameter int WORDS_PER_LINE = 4
);
  localparam int OFFSET_W = cache_clog2(WORDS_PER_LINE);
  localparam int LINE_W   = DATA_W * WORDS_PER_LINE;

  logic                     proc_read;
  logic                     proc_write;
  logic [ADDR_W-1:0]        proc_addr;
  logic [DATA_W-1:0]        proc_wdata;
  logic [DATA_W-1:0]        proc_rdata;
  logic                     proc_stall;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-OFFSET_W-1:0] mem_addr;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     mem_ready;

  // Environment side: drives CPU requests and memory responses.
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  // Cache side.
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_line_array.sv
// Cache line storage: valid/dirty bits (async cleared), tags and line data
// (not reset). One combinational read port, one line-fill or word write port.
module dcache_line_array #(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int OFFSET_W  = 2,
  parameter int TAG_W     = 25,
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [LINE_W-1:0]   rd_line_o,
  input  logic                line_we_i,
  input  logic                word_we_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [LINE_W-1:0]   wr_line_i,
  input  logic [DATA_W-1:0]   wr_word_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Status bits: a fill makes the line valid and clean, a word write dirties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
      dirty_q[wr_index_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end else if (word_we_i) begin
      data_q[wr_index_i][wr_offset_i*DATA_W +: DATA_W] <= wr_word_i;
    end
  end

  // Combinational read of the addressed line.
  always_comb begin
    rd_valid_o = valid_q[rd_index_i];
    rd_dirty_o = dirty_q[rd_index_i];
    rd_tag_o   = tag_q[rd_index_i];
    rd_line_o  = data_q[rd_index_i];
  end

endmodule

// File: rtl/riscv_dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with single-cycle
// hits. Misses stall the CPU while a whole line is written back and/or
// fetched over the memory handshake.
module riscv_dcache_wb
  import riscv_cache_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 30,
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         rst,
  riscv_dcache_wb_if.slave bus,
  output cache_state_e dbg_state_o
);

  localparam int OFFSET_W = cache_clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = cache_clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = DATA_W * WORDS_PER_LINE;

  cache_state_e       state_q, state_d;
  logic [INDEX_W-1:0] req_index_q, req_index_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  rd_index;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit, req_any, line_we, word_we;
  logic [DATA_W-1:0]   sel_word;

  assign offset  = bus.proc_addr[OFFSET_W-1:0];
  assign index   = bus.proc_addr[OFFSET_W +: INDEX_W];
  assign tag     = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign req_any = bus.proc_read | bus.proc_write;

  // Outside IDLE the array is addressed from the latched miss index so that
  // the memory-side outputs depend only on state and registers.
  assign rd_index = (state_q == ST_IDLE) ? index : req_index_q;
  assign hit      = rd_valid && (rd_tag == tag);
  assign sel_word = rd_line[offset*DATA_W +: DATA_W];

  assign dbg_state_o = state_q;

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .OFFSET_W  (OFFSET_W),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W),
    .LINE_W    (LINE_W)
  ) u_lines (
    .clk         (clk),
    .rst         (rst),
    .rd_index_i  (rd_index),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .line_we_i   (line_we),
    .word_we_i   (word_we),
    .wr_index_i  (line_we ? req_index_q : index),
    .wr_offset_i (offset),
    .wr_tag_i    (req_tag_q),
    .wr_line_i   (bus.mem_rdata),
    .wr_word_i   (bus.proc_wdata)
  );

  // State and latched miss address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_index_q <= '0;
      req_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_index_q <= req_index_d;
      req_tag_q   <= req_tag_d;
    end
  end

  // Next state, CPU-side responses and memory-side requests.
  always_comb begin
    state_d        = state_q;
    req_index_d    = req_index_q;
    req_tag_d      = req_tag_q;
    line_we        = 1'b0;
    word_we        = 1'b0;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (hit) begin
            // A simultaneous read and write is served as a write.
            if (bus.proc_write) word_we = 1'b1;
            else                bus.proc_rdata = sel_word;
          end else begin
            bus.proc_stall = 1'b1;
            req_index_d    = index;
            req_tag_d      = tag;
            state_d        = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {rd_tag, req_index_q};
        bus.mem_wdata  = rd_line;
        if (bus.mem_ready) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = {req_tag_q, req_index_q};
        if (bus.mem_ready) begin
          line_we = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_dcache_wb.sv
// Directed bench for riscv_dcache_wb with default geometry
// (offset 2 bits, index 3 bits, tag 25 bits).
module tb_riscv_dcache_wb;
  import riscv_cache_pkg::*;

  logic         clk;
  logic         rst;
  cache_state_e dbg_state;

  int n_checks;
  int n_pass;

  logic [127:0] saved_wdata;

  riscv_dcache_wb_if #(.DATA_W(32), .ADDR_W(30), .WORDS_PER_LINE(4)) bus ();

  riscv_dcache_wb #(
    .DATA_W         (32),
    .ADDR_W         (30),
    .NUM_LINES      (8),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock: 10 time-unit period; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cpu_req(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wdata);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
  endtask

  // Present a line with mem_ready for one clock, then drop ready.
  task automatic mem_respond(input logic [127:0] line);
    bus.mem_rdata = line;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    cpu_req(1'b0, 1'b0, 30'h0, 32'h0);
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 28'h0);
    check("rst_mem_wdata", bus.mem_wdata, 128'h0);
    check("rst_rdata", bus.proc_rdata, 32'h0);
    rst = 1'b0;

    // Cold read miss at 0x10 (index 4, tag 0)
    @(negedge clk);
    cpu_req(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    check("cold_stall", bus.proc_stall, 1'b1);
    check("cold_no_mem_read_yet", bus.mem_read, 1'b0);
    @(negedge clk);
    #1;
    check("cold_mem_read", bus.mem_read, 1'b1);
    check("cold_mem_addr", bus.mem_addr, 28'h4);
    check("cold_mem_write", bus.mem_write, 1'b0);
    check("cold_state", dbg_state, ST_ALLOCATE);
    mem_respond({32'h44, 32'h33, 32'h22, 32'h11});
    check("cold_done_stall", bus.proc_stall, 1'b0);
    check("cold_rdata", bus.proc_rdata, 32'h11);
    check("cold_done_mem_read", bus.mem_read, 1'b0);

    // Hits
    cpu_req(1'b1, 1'b0, 30'h11, 32'h0);
    #1;
    check("hit_stall", bus.proc_stall, 1'b0);
    check("hit_rdata", bus.proc_rdata, 32'h22);
    cpu_req(1'b0, 1'b1, 30'h12, 32'hDEADBEEF);
    #1;
    check("hit_wr_stall", bus.proc_stall, 1'b0);
    @(negedge clk);
    cpu_req(1'b1, 1'b0, 30'h12, 32'h0);
    #1;
    check("hit_rd_after_wr", bus.proc_rdata, 32'hDEADBEEF);
    check("hit_rd_after_wr_stall", bus.proc_stall, 1'b0);

    // Dirty eviction: 0x32 is index 4, tag 1, offset 2
    cpu_req(1'b1, 1'b0, 30'h32, 32'h0);
    #1;
    check("evict_stall", bus.proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check("wb_mem_write", bus.mem_write, 1'b1);
    check("wb_mem_addr", bus.mem_addr, 28'h4);
    check("wb_word2", bus.mem_wdata[95:64], 32'hDEADBEEF);
    check("wb_word0", bus.mem_wdata[31:0], 32'h11);
    check("wb_state", dbg_state, ST_WRITEBACK);
    saved_wdata = bus.mem_wdata;
    // Slow memory: three more cycles without ready
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("wb_hold_write", bus.mem_write, 1'b1);
      check("wb_hold_addr", bus.mem_addr, 28'h4);
      check("wb_hold_wdata", bus.mem_wdata, saved_wdata);
      check("wb_hold_stall", bus.proc_stall, 1'b1);
      check("wb_hold_no_read", bus.mem_read, 1'b0);
    end
    mem_respond('0);
    check("alloc_mem_read", bus.mem_read, 1'b1);
    check("alloc_mem_write", bus.mem_write, 1'b0);
    check("alloc_mem_addr", bus.mem_addr, 28'hC);
    check("alloc_stall", bus.proc_stall, 1'b1);
    mem_respond({32'hA4, 32'hA3, 32'hA2, 32'hA1});
    check("evict_done_stall", bus.proc_stall, 1'b0);
    check("evict_rdata", bus.proc_rdata, 32'hA3);

    // Clean eviction: line at index 4 now clean; re-read 0x12
    cpu_req(1'b1, 1'b0, 30'h12, 32'h0);
    #1;
    check("clean_stall", bus.proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check("clean_mem_read", bus.mem_read, 1'b1);
    check("clean_no_wb", bus.mem_write, 1'b0);
    check("clean_mem_addr", bus.mem_addr, 28'h4);
    mem_respond({32'hB4, 32'hB3, 32'hB2, 32'hB1});
    check("clean_done_stall", bus.proc_stall, 1'b0);
    check("clean_rdata", bus.proc_rdata, 32'hB3);

    // Reset in the middle of an ALLOCATE (0x52: index 4, tag 2)
    cpu_req(1'b1, 1'b0, 30'h52, 32'h0);
    @(negedge clk);
    #1;
    check("rstmid_mem_read_before", bus.mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_mem_read", bus.mem_read, 1'b0);
    check("rstmid_mem_addr", bus.mem_addr, 28'h0);
    cpu_req(1'b0, 1'b0, 30'h0, 32'h0);
    #1;
    check("rstmid_stall", bus.proc_stall, 1'b0);
    check("rstmid_rdata", bus.proc_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cpu_req(1'b1, 1'b0, 30'h11, 32'h0);
    #1;
    check("post_rst_miss_stall", bus.proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check("post_rst_mem_read", bus.mem_read, 1'b1);
    check("post_rst_mem_addr", bus.mem_addr, 28'h4);
    mem_respond({32'hC4, 32'hC3, 32'hC2, 32'hC1});
    check("post_rst_rdata", bus.proc_rdata, 32'hC2);
    cpu_req(1'b0, 1'b0, 30'h0, 32'h0);
    #1;
    check("idle_rdata_zero", bus.proc_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
